// File: rtl/frame_sched.sv
// Round-robin frame scheduler: grants one requester at a time, loads its frame
// into the addressed switch-instance serializer and waits for completion or timeout.
module frame_sched #(
  parameter int NUM_SW_INST = 5,
  parameter int FRAME_WIDTH = 32,
  parameter int TIMEOUT     = 16,
  localparam int GID_W      = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SW_INST-1:0]             req_valid,
  input  logic [NUM_SW_INST*FRAME_WIDTH-1:0] req_frame,
  output logic [NUM_SW_INST-1:0]             req_ready,
  output logic [NUM_SW_INST-1:0]             load_out,
  output logic [FRAME_WIDTH-1:0]             frame_out,
  input  logic [NUM_SW_INST-1:0]             done_in,
  output logic [GID_W-1:0]                   grant_id,
  output logic                               busy,
  output logic                               timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0]       TO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [GID_W-1:0] LAST_INIT  = GID_W'(NUM_SW_INST - 1);
  localparam logic [7:0]       CNT_MAX    = 8'hFF;

  state_t                   state_r;
  logic [GID_W-1:0]         last_grant_r;
  logic [GID_W-1:0]         grant_id_r;
  logic [FRAME_WIDTH-1:0]   frame_r;
  logic [NUM_SW_INST-1:0]   load_r;
  logic [7:0]               wait_cnt_r;

  logic                     win_found_s;
  logic [GID_W-1:0]         win_idx_s;
  logic [NUM_SW_INST-1:0]   win_onehot_s;
  logic [FRAME_WIDTH-1:0]   win_frame_s;
  logic                     done_g_s;
  logic                     timeout_hit_s;

  // Search from last+1 upward with wrap; an out-of-range last is treated as the top index.
  function automatic logic [GID_W:0] rr_pick(input logic [NUM_SW_INST-1:0] valid,
                                             input logic [GID_W-1:0]       last);
    logic             found;
    logic [GID_W-1:0] pick;
    logic [GID_W-1:0] idx_g;
    int               base;
    int               idx;
    found = 1'b0;
    pick  = '0;
    if (int'(last) >= NUM_SW_INST) begin
      base = NUM_SW_INST - 1;
    end else begin
      base = int'(last);
    end
    for (int k = 1; k <= NUM_SW_INST; k++) begin
      idx = base + k;
      if (idx >= NUM_SW_INST) begin
        idx = idx - NUM_SW_INST;
      end else begin
        idx = idx;
      end
      idx_g = GID_W'(idx);
      if (!found && valid[idx_g]) begin
        found = 1'b1;
        pick  = idx_g;
      end else begin
        found = found;
      end
    end
    return {found, pick};
  endfunction

  // Arbitration winner and its frame slice for the current IDLE cycle.
  always_comb begin
    {win_found_s, win_idx_s} = rr_pick(req_valid, last_grant_r);
    win_onehot_s = NUM_SW_INST'(1'b1) << win_idx_s;
    win_frame_s  = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (GID_W'(i) == win_idx_s) begin
        win_frame_s = req_frame[i*FRAME_WIDTH +: FRAME_WIDTH];
      end else begin
        win_frame_s = win_frame_s;
      end
    end
  end

  // Completion and abort qualifiers; done for the granted instance beats the timeout.
  always_comb begin
    done_g_s      = done_in[grant_id_r];
    timeout_hit_s = (state_r == ST_WAIT) && (wait_cnt_r == TO_LAST) && !done_g_s;
  end

  // Accept strobe and abort pulse are same-cycle indications, suppressed under reset.
  always_comb begin
    if (!rst && (state_r == ST_IDLE) && win_found_s) begin
      req_ready = win_onehot_s;
    end else begin
      req_ready = '0;
    end
    if (!rst && timeout_hit_s) begin
      timeout_err = 1'b1;
    end else begin
      timeout_err = 1'b0;
    end
  end

  // Scheduler FSM with registered frame, grant and load outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= LAST_INIT;
      grant_id_r   <= '0;
      frame_r      <= '0;
      load_r       <= '0;
      wait_cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            frame_r    <= win_frame_s;
            grant_id_r <= win_idx_s;
            load_r     <= win_onehot_s;
            wait_cnt_r <= 8'd0;
            state_r    <= ST_ISSUE;
          end else begin
            load_r     <= '0;
            state_r    <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          load_r     <= '0;
          wait_cnt_r <= 8'd0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          load_r <= '0;
          if (done_g_s || (wait_cnt_r == TO_LAST)) begin
            last_grant_r <= grant_id_r;
            state_r      <= ST_IDLE;
          end else begin
            if (wait_cnt_r != CNT_MAX) begin
              wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
              wait_cnt_r <= wait_cnt_r;
            end
            state_r <= ST_WAIT;
          end
        end
        default: begin
          load_r     <= '0;
          wait_cnt_r <= 8'd0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign load_out  = load_r;
  assign frame_out = frame_r;
  assign grant_id  = grant_id_r;
  assign busy      = (state_r == ST_ISSUE) || (state_r == ST_WAIT);

endmodule

// File: tb/tb_frame_sched.sv
// Directed self-checking bench for frame_sched: reset, single grant, round-robin,
// timeout, done-vs-timeout priority and reset in WAIT.
module tb_frame_sched;

  localparam int N  = 5;
  localparam int FW = 32;
  localparam int TO = 16;
  localparam int GW = 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*FW-1:0] req_frame;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    load_out;
  logic [FW-1:0]   frame_out;
  logic [N-1:0]    done_in;
  logic [GW-1:0]   grant_id;
  logic            busy;
  logic            timeout_err;

  int n_checks;
  int n_fail;

  frame_sched #(.NUM_SW_INST(N), .FRAME_WIDTH(FW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_frame(req_frame),
    .req_ready(req_ready), .load_out(load_out), .frame_out(frame_out),
    .done_in(done_in), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, still well before the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 5'b11111; done_in = 5'b00000;
    step(); step(); settle();
    n_checks++; if (load_out !== 5'b00000) begin n_fail++; $display("FAIL reset_load: got %b expected %b", load_out, 5'b00000); end
    n_checks++; if (frame_out !== 32'h0) begin n_fail++; $display("FAIL reset_frame: got %h expected %h", frame_out, 32'h0); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected %0d", grant_id, 0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected %b", timeout_err, 1'b0); end
    n_checks++; if (req_ready !== 5'b00000) begin n_fail++; $display("FAIL reset_ready: got %b expected %b", req_ready, 5'b00000); end
    req_valid = 5'b00000;
  endtask

  task automatic test_single();
    for (int i = 0; i < N; i++) req_frame[i*FW +: FW] = 32'hDEAD_0000 + i;
    req_frame[2*FW +: FW] = 32'h002A_5C07;
    step();
    rst = 1'b0; req_valid = 5'b00100; settle();
    n_checks++; if (req_ready !== 5'b00100) begin n_fail++; $display("FAIL single_ready: got %b expected %b", req_ready, 5'b00100); end
    n_checks++; if (load_out !== 5'b00000) begin n_fail++; $display("FAIL single_load_early: got %b expected %b", load_out, 5'b00000); end
    step();
    req_valid = 5'b00000; settle();
    n_checks++; if (load_out !== 5'b00100) begin n_fail++; $display("FAIL single_load: got %b expected %b", load_out, 5'b00100); end
    n_checks++; if (frame_out !== 32'h002A_5C07) begin n_fail++; $display("FAIL single_frame: got %h expected %h", frame_out, 32'h002A_5C07); end
    n_checks++; if (grant_id !== 3'd2) begin n_fail++; $display("FAIL single_grant: got %0d expected %0d", grant_id, 2); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected %b", busy, 1'b1); end
    step(); settle();
    n_checks++; if (load_out !== 5'b00000) begin n_fail++; $display("FAIL single_load_wait: got %b expected %b", load_out, 5'b00000); end
    n_checks++; if (frame_out !== 32'h002A_5C07) begin n_fail++; $display("FAIL single_frame_hold: got %h expected %h", frame_out, 32'h002A_5C07); end
    done_in = 5'b00100;
    step();
    done_in = 5'b00000; settle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done_idle: got %b expected %b", busy, 1'b0); end
    n_checks++; if (frame_out !== 32'h002A_5C07) begin n_fail++; $display("FAIL single_frame_after: got %h expected %h", frame_out, 32'h002A_5C07); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  exp_oh;
    logic [FW-1:0] exp_fr;
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) req_frame[i*FW +: FW] = 32'hA500_0010 + i;
    req_valid = 5'b11111;
    for (int r = 0; r < 6; r++) begin
      exp_oh = 5'b00001 << (r % N);
      exp_fr = 32'hA500_0010 + (r % N);
      settle();
      n_checks++; if (req_ready !== exp_oh) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", r, req_ready, exp_oh); end
      step(); settle();
      n_checks++; if (load_out !== exp_oh) begin n_fail++; $display("FAIL rr_load[%0d]: got %b expected %b", r, load_out, exp_oh); end
      n_checks++; if (grant_id !== 3'(r % N)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", r, grant_id, r % N); end
      n_checks++; if (frame_out !== exp_fr) begin n_fail++; $display("FAIL rr_frame[%0d]: got %h expected %h", r, frame_out, exp_fr); end
      n_checks++; if (req_ready !== 5'b00000) begin n_fail++; $display("FAIL rr_ready_busy[%0d]: got %b expected %b", r, req_ready, 5'b00000); end
      step();
      step();
      done_in = exp_oh;
      step();
      done_in = 5'b00000;
    end
    req_valid = 5'b00000;
  endtask

  task automatic test_timeout();
    req_valid = 5'b01000; settle();
    n_checks++; if (req_ready !== 5'b01000) begin n_fail++; $display("FAIL to_ready: got %b expected %b", req_ready, 5'b01000); end
    step();
    req_valid = 5'b00000; settle();
    n_checks++; if (load_out !== 5'b01000) begin n_fail++; $display("FAIL to_load: got %b expected %b", load_out, 5'b01000); end
    for (int k = 1; k <= TO; k++) begin
      step(); settle();
      n_checks++; if (timeout_err !== (k == TO)) begin n_fail++; $display("FAIL to_pulse[%0d]: got %b expected %b", k, timeout_err, (k == TO)); end
    end
    step(); settle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %b expected %b", busy, 1'b0); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse_end: got %b expected %b", timeout_err, 1'b0); end
    req_valid = 5'b11111; #1;
    n_checks++; if (req_ready !== 5'b10000) begin n_fail++; $display("FAIL to_next_search: got %b expected %b", req_ready, 5'b10000); end
    req_valid = 5'b00000;
  endtask

  task automatic test_done_wins();
    step();
    req_valid = 5'b00010; settle();
    n_checks++; if (req_ready !== 5'b00010) begin n_fail++; $display("FAIL dw_ready: got %b expected %b", req_ready, 5'b00010); end
    step();
    req_valid = 5'b00000;
    step();
    for (int k = 1; k < TO; k++) begin
      done_in = (k == 3) ? 5'b01000 : 5'b00000;
      settle();
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL dw_no_to[%0d]: got %b expected %b", k, timeout_err, 1'b0); end
      step();
      done_in = 5'b00000; settle();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dw_stay_wait[%0d]: got %b expected %b", k, busy, 1'b1); end
    end
    done_in = 5'b00010; settle();
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL dw_tie_no_to: got %b expected %b", timeout_err, 1'b0); end
    step();
    done_in = 5'b00000; settle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dw_complete: got %b expected %b", busy, 1'b0); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL dw_after: got %b expected %b", timeout_err, 1'b0); end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < N; i++) req_frame[i*FW +: FW] = 32'h0BAD_0100 + i;
    req_valid = 5'b00001; settle();
    n_checks++; if (req_ready !== 5'b00001) begin n_fail++; $display("FAIL rmw_ready: got %b expected %b", req_ready, 5'b00001); end
    step();
    req_valid = 5'b00000;
    step(); step();
    rst = 1'b1; req_valid = 5'b11111; settle();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmw_in_wait: got %b expected %b", busy, 1'b1); end
    n_checks++; if (req_ready !== 5'b00000) begin n_fail++; $display("FAIL rmw_ready_rst: got %b expected %b", req_ready, 5'b00000); end
    step(); settle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmw_busy: got %b expected %b", busy, 1'b0); end
    n_checks++; if (frame_out !== 32'h0) begin n_fail++; $display("FAIL rmw_frame: got %h expected %h", frame_out, 32'h0); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL rmw_grant: got %0d expected %0d", grant_id, 0); end
    n_checks++; if (load_out !== 5'b00000) begin n_fail++; $display("FAIL rmw_load: got %b expected %b", load_out, 5'b00000); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rmw_timeout: got %b expected %b", timeout_err, 1'b0); end
    rst = 1'b0; settle();
    n_checks++; if (req_ready !== 5'b00001) begin n_fail++; $display("FAIL rmw_first: got %b expected %b", req_ready, 5'b00001); end
    step();
    req_valid = 5'b00000; settle();
    n_checks++; if (load_out !== 5'b00001) begin n_fail++; $display("FAIL rmw_load0: got %b expected %b", load_out, 5'b00001); end
    n_checks++; if (frame_out !== 32'h0BAD_0100) begin n_fail++; $display("FAIL rmw_frame0: got %h expected %h", frame_out, 32'h0BAD_0100); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; req_valid = '0; req_frame = '0; done_in = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_wins();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
